// File: rtl/npu_input_framer.sv
// npu_input_framer: buffers a valid/ready pixel stream and re-times it into
// gap-free, line-contiguous de/data bursts with horizontal and vertical
// blanking, using the upstream SOF mark to keep frames aligned.
module npu_input_framer #(
  parameter int H_ACTIVE   = 28,
  parameter int V_ACTIVE   = 28,
  parameter int H_BLANK    = 4,
  parameter int V_BLANK    = 2,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  input  logic                        s_sof,
  output logic                        s_ready,
  output logic                        de_out,
  output logic [7:0]                  data_out,
  output logic                        sof_out,
  output logic                        eol_out,
  output logic                        frame_done,
  output logic                        sof_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int PW     = $clog2(H_ACTIVE);
  localparam int LNW    = $clog2(V_ACTIVE);
  localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int CW     = $clog2(VB_CYC + H_BLANK + 1);

  typedef enum logic [2:0] {SYNC, WAIT_LINE, ACTIVE, HBLANK, VBLANK} state_e;

  // FIFO: entry is {sof, pixel}
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push, pop, fifo_empty;
  logic [8:0]    head;

  state_e         state_q, state_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic [LNW-1:0] line_q, line_d;
  logic [CW-1:0]  blk_q, blk_d;
  logic           de_q, de_d, sof_q, sof_d, eol_q, eol_d, fd_q, fd_d, err_q, err_d;
  logic [7:0]     data_q, data_d;
  logic           first_px, last_px;

  // Ready looks only at the registered level, so a same-cycle pop never
  // lets a push into a full FIFO.
  assign s_ready    = (level_q < LW'(FIFO_DEPTH));
  assign push       = s_valid & s_ready;
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign first_px   = (line_q == '0) && (pix_q == '0);
  assign last_px    = (pix_q == PW'(H_ACTIVE - 1));

  assign de_out     = de_q;
  assign data_out   = data_q;
  assign sof_out    = sof_q;
  assign eol_out    = eol_q;
  assign frame_done = fd_q;
  assign sof_err    = err_q;
  assign fifo_level = level_q;

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_sof, s_data};
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Framing FSM: next state, pops and next output values.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    blk_d   = blk_q;
    pop     = 1'b0;
    de_d    = 1'b0;
    data_d  = data_q;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    fd_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      SYNC: begin
        pix_d  = '0;
        line_d = '0;
        blk_d  = '0;
        // Drop junk until a frame start sits at the head; keep that entry.
        if (!fifo_empty) begin
          if (head[8]) state_d = WAIT_LINE;
          else         pop     = 1'b1;
        end
      end
      WAIT_LINE: begin
        // A whole line must be queued so the burst cannot starve mid-line.
        if (level_q >= LW'(H_ACTIVE)) begin
          state_d = ACTIVE;
          pix_d   = '0;
        end
      end
      ACTIVE: begin
        if (!fifo_empty) begin
          if (head[8] && !first_px) begin
            // New frame arrived early: abandon this one, keep the SOF pixel.
            err_d   = 1'b1;
            state_d = SYNC;
          end else begin
            pop    = 1'b1;
            de_d   = 1'b1;
            data_d = head[7:0];
            sof_d  = first_px;
            eol_d  = last_px;
            if (last_px) begin
              pix_d = '0;
              blk_d = '0;
              if (line_q < LNW'(V_ACTIVE - 1)) begin
                line_d  = line_q + 1'b1;
                state_d = HBLANK;
              end else begin
                state_d = VBLANK;
              end
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
      end
      HBLANK: begin
        if (blk_q == CW'(H_BLANK - 1)) begin
          blk_d   = '0;
          state_d = WAIT_LINE;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      VBLANK: begin
        fd_d = (blk_q == '0);
        if (blk_q == CW'(VB_CYC - 1)) begin
          blk_d   = '0;
          state_d = SYNC;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      pix_q   <= '0;
      line_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      blk_q   <= blk_d;
    end
  end

  // Registered video outputs; reset drops de_out immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q   <= 1'b0;
      data_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      fd_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      de_q   <= de_d;
      data_q <= data_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
      fd_q   <= fd_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_npu_input_framer.sv
// Bench for npu_input_framer: queue-based feeder, expected-stream scoreboard
// checked every cycle, plus literal timing/occupancy expectations.
module tb_npu_input_framer;
  localparam int HA = 28;
  localparam int FRM = 784;

  logic       clk, reset, s_valid, s_sof, s_ready;
  logic [7:0] s_data, data_out;
  logic       de_out, sof_out, eol_out, frame_done, sof_err;
  logic [5:0] fifo_level;

  npu_input_framer dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
    .s_ready(s_ready), .de_out(de_out), .data_out(data_out), .sof_out(sof_out),
    .eol_out(eol_out), .frame_done(frame_done), .sof_err(sof_err), .fifo_level(fifo_level)
  );

  typedef struct packed { logic real_px; logic sof; logic [7:0] d; } in_t;
  typedef struct packed { logic [7:0] d; logic sof; logic eol; logic lof; } exp_t;

  in_t  in_q[$];
  exp_t exp_q[$];
  int   pc_q[$];   // edge index of every accepted real pixel

  int n_chk = 0, n_fail = 0;
  int cyc = 0, emitted = 0, fd_cnt = 0, sof_cyc = 0, sofpush_cyc = 0;
  int frm_pix = 0, low_run = 0, gmin = 999, gmax = 0, bp_max = 0;
  int duty = 1, idle = 0, k;
  bit in_line = 0, prev_lof = 0, bp_arm = 0, bp_full = 0, thr_arm = 0, flush = 0, took = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pxval(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(i * 3 + 7);
      2:       return 8'(255 - i);
      3:       return 8'(i * 5 + 1);
      4:       return 8'(i + 100);
      5:       return 8'(i * 7);
      default: return 8'(i ^ 'h5A);
    endcase
  endfunction

  // Queue npx pixels of a frame and their expected output form.
  task automatic add_frame(input int kind, input int npx);
    for (int i = 0; i < npx; i++) begin
      in_t  x;
      exp_t e;
      x.real_px = 1'b1; x.sof = (i == 0); x.d = pxval(kind, i);
      in_q.push_back(x);
      e.d = x.d; e.sof = (i == 0); e.eol = ((i % HA) == HA - 1); e.lof = (i == FRM - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(in_q.size() == 0 && exp_q.size() == 0, nm, exp_q.size(), 0);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Feeder: drives in_q at negedges, holding valid until accepted.
  initial begin
    s_valid = 0; s_data = 0; s_sof = 0;
    forever begin
      @(negedge clk);
      if (flush) begin
        in_q.delete();
        s_valid = 0; s_sof = 0; took = 0; idle = 0;
      end else begin
        if (took) begin
          if (in_q[0].real_px) pc_q.push_back(cyc);
          if (in_q[0].sof) sofpush_cyc = cyc;
          void'(in_q.pop_front());
          idle = duty - 1;
        end
        if (idle > 0) begin
          idle--;
          s_valid = 0;
        end else if (in_q.size() > 0) begin
          s_valid = 1; s_data = in_q[0].d; s_sof = in_q[0].sof;
        end else begin
          s_valid = 0; s_sof = 0;
        end
        took = s_valid && s_ready;
      end
    end
  end

  // Compare process: every cycle against the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk(de_out == 0, "de_in_reset", de_out, 0);
        in_line = 0; prev_lof = 0; frm_pix = 0; low_run = 0;
        continue;
      end
      chk(frame_done == prev_lof, "frame_done", frame_done, prev_lof);
      if (frame_done) fd_cnt++;
      chk(s_ready == (fifo_level < 32), "s_ready", s_ready, fifo_level < 32);
      chk(fifo_level <= 32, "fifo_bound", fifo_level, 32);
      if (bp_arm) begin
        if (fifo_level > bp_max) bp_max = fifo_level;
        if (fifo_level == 32 && !s_ready) bp_full = 1;
      end
      prev_lof = 0;
      if (de_out) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_de", data_out, -1);
        end else begin
          e = exp_q.pop_front();
          if (!in_line) begin
            chk(pc_q.size() >= emitted + HA, "line_buffered", pc_q.size(), emitted + HA);
            if (thr_arm && pc_q.size() >= emitted + HA)
              chk(cyc - pc_q[emitted + HA - 1] == 2, "line_latency", cyc - pc_q[emitted + HA - 1], 2);
            if (!e.sof) begin
              if (low_run < gmin) gmin = low_run;
              if (low_run > gmax) gmax = low_run;
            end
          end
          chk(data_out == e.d, "data", data_out, e.d);
          chk(sof_out == e.sof, "sof_out", sof_out, e.sof);
          chk(eol_out == e.eol, "eol_out", eol_out, e.eol);
          if (e.sof) begin sof_cyc = cyc; frm_pix = 0; end
          frm_pix++;
          emitted++;
          in_line  = !e.eol;
          prev_lof = e.lof;
        end
        low_run = 0;
      end else begin
        // A drop inside a line is legal only when a new frame is next.
        if (in_line) begin
          chk(exp_q.size() > 0 && exp_q[0].sof, "de_gap", 0, 1);
          in_line = 0;
        end
        low_run++;
      end
    end
  end

  initial begin
    reset = 1;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk(de_out == 0, "rst_de", de_out, 0);
    chk(data_out == 0, "rst_data", data_out, 0);
    chk(fifo_level == 0, "rst_level", fifo_level, 0);
    chk(frame_done == 0 && sof_out == 0 && eol_out == 0, "rst_flags", frame_done, 0);
    chk(sof_err == 0, "rst_err", sof_err, 0);
    reset = 1;
    @(negedge clk);
    chk(s_ready == 1, "ready_after_rst", s_ready, 1);

    // Basic frame, full rate.
    add_frame(0, FRM);
    chk(exp_q[0].sof == 1 && exp_q[0].eol == 0, "model_px0", exp_q[0].sof, 1);
    chk(exp_q[27].eol == 1, "model_eol27", exp_q[27].eol, 1);
    chk(exp_q[300].d == 44, "model_d300", exp_q[300].d, 44);
    chk(exp_q[783].lof == 1 && exp_q[783].eol == 1, "model_last", exp_q[783].lof, 1);
    gmin = 999; gmax = 0;
    drain(3000, "basic_drain");
    repeat (80) @(negedge clk);
    chk(sof_cyc - sofpush_cyc == 29, "first_latency", sof_cyc - sofpush_cyc, 29);
    chk(gmin == 5, "gap_min", gmin, 5);
    chk(gmax == 5, "gap_max", gmax, 5);
    chk(fd_cnt == 1, "fd_basic", fd_cnt, 1);

    // Leading junk then the same frame.
    for (int j = 0; j < 5; j++) begin
      in_t x;
      x.real_px = 0; x.sof = 0; x.d = 8'(8'hE0 + j);
      in_q.push_back(x);
    end
    add_frame(0, FRM);
    drain(3000, "junk_drain");
    repeat (80) @(negedge clk);
    chk(sof_err == 0, "junk_err", sof_err, 0);
    chk(fd_cnt == 2, "fd_junk", fd_cnt, 2);

    // Throttled input at 25% duty.
    duty = 4; gmin = 999; thr_arm = 1;
    add_frame(1, FRM);
    drain(6000, "thr_drain");
    thr_arm = 0; duty = 1;
    chk(gmin >= 5, "thr_gap_min", gmin, 5);

    // Burst into the FIFO while VBLANK holds the output.
    bp_arm = 1; bp_max = 0; bp_full = 0;
    add_frame(2, FRM);
    drain(3000, "bp_drain");
    bp_arm = 0;
    repeat (80) @(negedge clk);
    chk(bp_max == 32, "bp_max_level", bp_max, 32);
    chk(bp_full == 1, "bp_ready_low", bp_full, 1);
    chk(fd_cnt == 4, "fd_bp", fd_cnt, 4);

    // SOF at line 3 pixel 10: truncated frame, then a clean one.
    chk(sof_err == 0, "pre_abort_err", sof_err, 0);
    add_frame(3, 3 * HA + 10);
    add_frame(4, FRM);
    drain(4000, "abort_drain");
    repeat (80) @(negedge clk);
    chk(sof_err == 1, "abort_err", sof_err, 1);
    chk(fd_cnt == 5, "fd_abort", fd_cnt, 5);
    repeat (20) @(negedge clk);
    chk(sof_err == 1, "abort_err_sticky", sof_err, 1);

    // Asynchronous reset at line 5 pixel 12.
    frm_pix = 0;
    add_frame(5, FRM);
    k = 0;
    while (frm_pix < 5 * HA + 13 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(frm_pix >= 5 * HA + 13, "reach_l5p12", frm_pix, 5 * HA + 13);
    @(posedge clk);
    #2;
    chk(de_out == 1, "pre_rst_de", de_out, 1);
    reset = 0; flush = 1;
    exp_q.delete(); pc_q.delete(); emitted = 0;
    #1;
    chk(de_out == 0, "async_de", de_out, 0);
    chk(fifo_level == 0, "async_level", fifo_level, 0);
    chk(sof_err == 0, "async_err", sof_err, 0);
    repeat (2) @(negedge clk);
    reset = 1; flush = 0;
    @(negedge clk);
    chk(s_ready == 1, "ready_after_async", s_ready, 1);
    chk(fifo_level == 0, "level_after_async", fifo_level, 0);

    // Full frame after the reset.
    add_frame(6, FRM);
    drain(3000, "post_rst_drain");
    repeat (80) @(negedge clk);
    chk(fd_cnt == 6, "fd_post_rst", fd_cnt, 6);
    chk(sof_err == 0, "post_rst_err", sof_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
